// File: rtl/riscv_pkg.sv
// Shared types and constants for the store write buffer and its consumers.
//
// Contents:
//   StoreBufferDepth     default number of buffered stores
//   StoreBufferXlen      default data width
//   StoreBufferMmioAddr  first MMIO byte address
//   store_buffer_state_t fence FSM states
//   store_buffer_entry_t one buffered store, as the buffer holds it
//   from_store_buffer_t  bundle of flags the hazard unit consumes
package riscv_pkg;

    localparam int          StoreBufferDepth    = 4;
    localparam int          StoreBufferXlen     = 32;
    localparam logic [31:0] StoreBufferMmioAddr = 32'h4000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } store_buffer_state_t;

    typedef struct packed {
        logic [31:2]                  addr;
        logic [StoreBufferXlen-1:0]   data;
        logic [StoreBufferXlen/8-1:0] byte_en;
        logic                         valid;
    } store_buffer_entry_t;

    typedef struct packed {
        logic ld_conflict;
        logic fence_done;
        logic empty;
    } from_store_buffer_t;

endpackage

// File: rtl/store_buffer_match.sv
// Combinational comparator array: checks a load query against every
// buffered store and flags the entries it overlaps.
//
// Ports:
//   entry_word     word address [31:2] of each entry
//   entry_byte_en  byte enables of each entry
//   entry_valid    entry holds a pending store
//   ld_word        load word address [31:2]
//   ld_byte_en     bytes the load reads
//   match_vec      per-entry overlap flag
//   any_match      OR of match_vec
module store_buffer_match
    import riscv_pkg::*;
#(
    parameter int DEPTH = StoreBufferDepth,
    parameter int XLEN  = StoreBufferXlen
) (
    input  logic [DEPTH-1:0][29:0]       entry_word,
    input  logic [DEPTH-1:0][XLEN/8-1:0] entry_byte_en,
    input  logic [DEPTH-1:0]             entry_valid,
    input  logic [29:0]                  ld_word,
    input  logic [XLEN/8-1:0]            ld_byte_en,
    output logic [DEPTH-1:0]             match_vec,
    output logic                         any_match
);

    // An entry overlaps the load only if it is live, sits in the same word
    // and shares at least one byte lane with it. Disjoint lanes in the same
    // word do not conflict.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = entry_valid[i]
                         && (entry_word[i] == ld_word)
                         && (|(entry_byte_en[i] & ld_byte_en));
        end
    end

    assign any_match = |match_vec;

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: queues committed stores from MA in a small FIFO and
// drains them to data memory. Also answers load-conflict queries and
// implements the fence drain handshake.
//
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_st_valid/o_st_ready           store enqueue handshake
//   i_st_addr/i_st_data/i_st_byte_en store fields
//   o_mem_valid/i_mem_ready         memory request handshake (head entry)
//   o_mem_addr/o_mem_wdata/o_mem_byte_en head entry fields
//   i_ld_valid/i_ld_addr/i_ld_byte_en load query
//   o_ld_conflict                   load must stall
//   i_fence/o_fence_done            drain request / one-cycle completion pulse
//   o_count/o_empty                 occupancy
module store_write_buffer
    import riscv_pkg::*;
#(
    parameter int          DEPTH     = StoreBufferDepth,
    parameter int          XLEN      = StoreBufferXlen,
    parameter logic [31:0] MMIO_ADDR = StoreBufferMmioAddr
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_st_valid,
    output logic                       o_st_ready,
    input  logic [31:0]                i_st_addr,
    input  logic [XLEN-1:0]            i_st_data,
    input  logic [XLEN/8-1:0]          i_st_byte_en,
    output logic                       o_mem_valid,
    input  logic                       i_mem_ready,
    output logic [31:0]                o_mem_addr,
    output logic [XLEN-1:0]            o_mem_wdata,
    output logic [XLEN/8-1:0]          o_mem_byte_en,
    input  logic                       i_ld_valid,
    input  logic [31:0]                i_ld_addr,
    input  logic [XLEN/8-1:0]          i_ld_byte_en,
    output logic                       o_ld_conflict,
    input  logic                       i_fence,
    output logic                       o_fence_done,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int             PW         = $clog2(DEPTH);
    localparam int             CW         = PW + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0]  ONE_COUNT  = CW'(1);

    logic [DEPTH-1:0][29:0]       entry_word;
    logic [DEPTH-1:0][XLEN-1:0]   entry_data;
    logic [DEPTH-1:0][XLEN/8-1:0] entry_byte_en;
    logic [DEPTH-1:0]             entry_valid;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    store_buffer_state_t state;
    store_buffer_state_t state_next;

    logic               enq;
    logic               deq;
    logic [DEPTH-1:0]   match_vec;
    logic               any_match;
    logic               mmio_hit;
    from_store_buffer_t hazard_view;

    // Ready depends only on registered count and state, so a dequeue in
    // the same cycle as a full buffer cannot open the door for an enqueue.
    assign o_st_ready  = (count != FULL_COUNT) && (state != DRAIN);
    assign o_mem_valid = (count != '0);
    assign enq         = i_st_valid && o_st_ready;
    assign deq         = o_mem_valid && i_mem_ready;

    assign o_mem_addr    = {entry_word[head], 2'b00};
    assign o_mem_wdata   = entry_data[head];
    assign o_mem_byte_en = entry_byte_en[head];

    // FIFO storage and pointers. Enqueue and dequeue never hit the same
    // slot in one cycle: that would need count==0 with a dequeue.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (deq) begin
                entry_valid[head] <= 1'b0;
                head              <= head + 1'b1;
            end
            if (enq) begin
                entry_word[tail]    <= i_st_addr[31:2];
                entry_data[tail]    <= i_st_data;
                entry_byte_en[tail] <= i_st_byte_en;
                entry_valid[tail]   <= 1'b1;
                tail                <= tail + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

    // Fence FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fence FSM next state. DRAIN finishes on the cycle the last entry is
    // accepted by memory, so the done pulse lands on the following cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_fence) begin
                    state_next = (count != '0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if ((count == '0) || ((count == ONE_COUNT) && deq)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_match (
        .entry_word    (entry_word),
        .entry_byte_en (entry_byte_en),
        .entry_valid   (entry_valid),
        .ld_word       (i_ld_addr[31:2]),
        .ld_byte_en    (i_ld_byte_en),
        .match_vec     (match_vec),
        .any_match     (any_match)
    );

    // Any load to MMIO waits until every older store has left, since MMIO
    // reads may have side effects that depend on prior writes. A head entry
    // dequeuing this cycle is still valid here and still counts.
    assign mmio_hit = (i_ld_addr >= MMIO_ADDR) && (count != '0);

    assign hazard_view.ld_conflict = i_ld_valid && (any_match || mmio_hit);
    assign hazard_view.fence_done  = (state == DONE);
    assign hazard_view.empty       = (count == '0);

    assign o_ld_conflict = hazard_view.ld_conflict;
    assign o_fence_done  = hazard_view.fence_done;
    assign o_empty       = hazard_view.empty;
    assign o_count       = count;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer. A queue of expected stores is
// filled whenever the bench expects an enqueue to be accepted and is popped
// whenever the bench expects the head to be accepted by memory; occupancy,
// ready, valid and the fence pulse are predicted from that queue and a
// small fence-state model.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic        i_clk;
    logic        i_rst;
    logic        i_st_valid;
    logic        o_st_ready;
    logic [31:0] i_st_addr;
    logic [31:0] i_st_data;
    logic [3:0]  i_st_byte_en;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_byte_en;
    logic        i_ld_valid;
    logic [31:0] i_ld_addr;
    logic [3:0]  i_ld_byte_en;
    logic        o_ld_conflict;
    logic        i_fence;
    logic        o_fence_done;
    logic [2:0]  o_count;
    logic        o_empty;

    exp_t sb[$];
    int   fsm;
    int   assertCount;
    int   failCount;

    store_write_buffer dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_st_valid    (i_st_valid),
        .o_st_ready    (o_st_ready),
        .i_st_addr     (i_st_addr),
        .i_st_data     (i_st_data),
        .i_st_byte_en  (i_st_byte_en),
        .o_mem_valid   (o_mem_valid),
        .i_mem_ready   (i_mem_ready),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .o_mem_byte_en (o_mem_byte_en),
        .i_ld_valid    (i_ld_valid),
        .i_ld_addr     (i_ld_addr),
        .i_ld_byte_en  (i_ld_byte_en),
        .o_ld_conflict (o_ld_conflict),
        .i_fence       (i_fence),
        .o_fence_done  (o_fence_done),
        .o_count       (o_count),
        .o_empty       (o_empty)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one store on the MA side; acceptance is decided in tick().
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] be);
        i_st_valid   = 1'b1;
        i_st_addr    = addr;
        i_st_data    = data;
        i_st_byte_en = be;
    endtask

    task automatic setLoad(input logic v, input logic [31:0] addr,
                           input logic [3:0] be);
        i_ld_valid   = v;
        i_ld_addr    = addr;
        i_ld_byte_en = be;
        #1;
    endtask

    // Advance one clock. Before the edge, check the registered outputs
    // against the model and retire/admit stores in the scoreboard; then
    // step the fence model. Returns 1 ns after the rising edge.
    task automatic tick();
        int   sz;
        bit   mready;
        bit   expEnq;
        bit   expDeq;
        exp_t head;
        sz     = sb.size();
        mready = (sz != DEPTH) && (fsm != 1);
        checkOutput("count", 32'(o_count), 32'(sz));
        checkOutput("mem_valid", 32'(o_mem_valid), 32'(sz != 0));
        checkOutput("st_ready", 32'(o_st_ready), 32'(mready));
        checkOutput("fence_done", 32'(o_fence_done), 32'(fsm == 2));
        if (i_rst) begin
            sb.delete();
            fsm = 0;
        end else begin
            expDeq = (sz != 0) && i_mem_ready;
            expEnq = i_st_valid && mready;
            if (expDeq) begin
                head = sb.pop_front();
                checkOutput("mem_addr", o_mem_addr, head.addr);
                checkOutput("mem_wdata", o_mem_wdata, head.data);
                checkOutput("mem_byte_en", 32'(o_mem_byte_en), 32'(head.be));
            end
            if (expEnq) begin
                sb.push_back('{addr: i_st_addr & 32'hFFFF_FFFC,
                               data: i_st_data, be: i_st_byte_en});
            end
            case (fsm)
                0: if (i_fence) fsm = (sz != 0) ? 1 : 2;
                1: if ((sz == 0) || ((sz == 1) && expDeq)) fsm = 2;
                default: fsm = 0;
            endcase
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        assertCount  = 0;
        failCount    = 0;
        fsm          = 0;
        i_rst        = 1'b1;
        i_st_valid   = 1'b0;
        i_st_addr    = '0;
        i_st_data    = '0;
        i_st_byte_en = '0;
        i_mem_ready  = 1'b0;
        i_ld_valid   = 1'b0;
        i_ld_addr    = '0;
        i_ld_byte_en = '0;
        i_fence      = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;

        // Reset values
        checkOutput("rst_mem_valid", 32'(o_mem_valid), 32'd0);
        checkOutput("rst_st_ready", 32'(o_st_ready), 32'd1);
        checkOutput("rst_empty", 32'(o_empty), 32'd1);
        checkOutput("rst_conflict", 32'(o_ld_conflict), 32'd0);
        checkOutput("rst_fence_done", 32'(o_fence_done), 32'd0);
        checkOutput("rst_count", 32'(o_count), 32'd0);

        // Fill with memory stalled, then drain in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF);
            tick();
        end
        i_st_valid = 1'b0;
        checkOutput("full_ready", 32'(o_st_ready), 32'd0);
        checkOutput("full_count", 32'(o_count), 32'd4);
        checkOutput("full_empty", 32'(o_empty), 32'd0);
        // Full plus simultaneous dequeue: the offered store is refused
        applyStimulus(32'h500, 32'hDEAD_BEEF, 4'hF);
        i_mem_ready = 1'b1;
        tick();
        i_st_valid = 1'b0;
        repeat (3) tick();
        checkOutput("drain_empty", 32'(o_empty), 32'd1);
        tick();

        // Byte-lane aliasing
        i_mem_ready = 1'b0;
        applyStimulus(32'h200, 32'hAABB_CCDD, 4'b0100);
        tick();
        i_st_valid = 1'b0;
        setLoad(1'b1, 32'h202, 4'b0100);
        checkOutput("alias_same_lane", 32'(o_ld_conflict), 32'd1);
        setLoad(1'b1, 32'h203, 4'b1000);
        checkOutput("alias_other_lane", 32'(o_ld_conflict), 32'd0);
        setLoad(1'b1, 32'h206, 4'b0100);
        checkOutput("alias_other_word", 32'(o_ld_conflict), 32'd0);
        setLoad(1'b0, 32'h202, 4'b0100);
        checkOutput("alias_no_valid", 32'(o_ld_conflict), 32'd0);
        i_mem_ready = 1'b1;
        setLoad(1'b1, 32'h202, 4'b0100);
        checkOutput("alias_while_deq", 32'(o_ld_conflict), 32'd1);
        tick();
        setLoad(1'b1, 32'h202, 4'b0100);
        checkOutput("alias_after_drain", 32'(o_ld_conflict), 32'd0);

        // MMIO loads wait for any pending store, even a zero-enable one
        i_mem_ready = 1'b0;
        applyStimulus(32'h300, 32'h1234_5678, 4'b0000);
        tick();
        i_st_valid = 1'b0;
        setLoad(1'b1, 32'h4000_0000, 4'hF);
        checkOutput("mmio_pending", 32'(o_ld_conflict), 32'd1);
        setLoad(1'b1, 32'h3FFF_FFFC, 4'hF);
        checkOutput("below_mmio", 32'(o_ld_conflict), 32'd0);
        setLoad(1'b1, 32'h300, 4'hF);
        checkOutput("zero_be_no_alias", 32'(o_ld_conflict), 32'd0);
        i_mem_ready = 1'b1;
        tick();
        setLoad(1'b1, 32'h4000_0000, 4'hF);
        checkOutput("mmio_empty", 32'(o_ld_conflict), 32'd0);
        setLoad(1'b0, 32'h0, 4'h0);

        // Steady state at count 2 with wrap
        i_mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(32'h600 + 32'(4 * i), $urandom, 4'(i + 1));
            tick();
        end
        i_mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(32'h700 + 32'(4 * i) + 32'(i % 4), $urandom,
                          4'($urandom_range(0, 15)));
            tick();
        end
        i_st_valid = 1'b0;
        repeat (3) tick();

        // Fence with three pending stores
        i_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h800 + 32'(4 * i), $urandom, 4'hF);
            tick();
        end
        i_st_valid = 1'b0;
        i_fence    = 1'b1;
        tick();
        i_fence = 1'b0;
        applyStimulus(32'h900, 32'hCAFE_F00D, 4'hF);
        tick();
        checkOutput("drain_ready", 32'(o_st_ready), 32'd0);
        i_mem_ready = 1'b1;
        i_fence     = 1'b1;
        tick();
        i_fence    = 1'b0;
        i_st_valid = 1'b0;
        repeat (2) tick();
        checkOutput("fence_pulse", 32'(o_fence_done), 32'd1);
        repeat (2) tick();

        // Fence on an empty buffer
        i_fence = 1'b1;
        tick();
        i_fence = 1'b0;
        checkOutput("empty_fence_pulse", 32'(o_fence_done), 32'd1);
        repeat (2) tick();

        // Reset while memory holds off the head store
        i_mem_ready = 1'b0;
        applyStimulus(32'hA00, 32'h5555_AAAA, 4'hF);
        tick();
        i_st_valid = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checkOutput("rst_mid_valid", 32'(o_mem_valid), 32'd0);
        checkOutput("rst_mid_count", 32'(o_count), 32'd0);
        checkOutput("rst_mid_ready", 32'(o_st_ready), 32'd1);
        i_mem_ready = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Memory-side counterpart of the L0 data cache's write-through path.
- Accepts committed stores from the MA stage: word-aligned address, data and byte enables, the same fields the cache writes.
- Queues them in a small FIFO and drains them to data memory over a valid/ready request channel.
- Answers single-cycle load-conflict queries so the hazard unit can stall loads that alias a pending store or target MMIO while stores are outstanding.

Parameters:
- DEPTH, 4, number of buffered stores (power of 2, >=2)
- XLEN, 32, data width
- MMIO_ADDR, 32'h4000_0000, addresses >= this are MMIO

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_st_valid  in  1  store offered from MA
- o_st_ready  out  1  buffer can accept a store
- i_st_addr  in  32  store byte address
- i_st_data  in  XLEN  store data, already lane-aligned
- i_st_byte_en  in  XLEN/8  byte write enables
- o_mem_valid  out  1  head store presented to memory
- i_mem_ready  in  1  memory accepts head store
- o_mem_addr  out  32  head address, word-aligned, [1:0]=0
- o_mem_wdata  out  XLEN  head data
- o_mem_byte_en  out  XLEN/8  head byte enables
- i_ld_valid  in  1  load query from EX
- i_ld_addr  in  32  load byte address
- i_ld_byte_en  in  XLEN/8  bytes the load reads
- o_ld_conflict  out  1  load must stall
- i_fence  in  1  fence/AMO requests drain
- o_fence_done  out  1  drain complete
- o_count  out  $clog2(DEPTH)+1  occupancy
- o_empty  out  1  occupancy==0

Behaviour:
- Reset: clock i_clk; reset i_rst, synchronous, active-high.
  - head, tail, count <= 0.
  - FSM <= IDLE.
  - Entry valid bits cleared; all buffered stores are discarded.
- Reset-time output values:
  - o_mem_valid=0, o_st_ready=1, o_empty=1.
  - o_ld_conflict=0, o_fence_done=0, o_count=0.
- Enqueue: occurs when i_st_valid & o_st_ready.
  - Writes entry[tail]; tail <= tail+1, wrapping modulo DEPTH.
  - o_st_ready = (count!=DEPTH) & (state!=DRAIN).
  - When full, a simultaneous dequeue does not open ready in the same cycle.
- Dequeue: occurs when o_mem_valid & i_mem_ready.
  - head <= head+1, wrapping; the entry's valid bit is cleared.
  - o_mem_valid = (count!=0), driven from registered entry[head].
- Latency: a store enqueued at cycle N can first appear on the memory port at cycle N+1; there is no combinational pass-through.
- Stability: while o_mem_valid & ~i_mem_ready, the o_mem_* outputs stay stable.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
  - At count==1 the new entry becomes head on the next cycle.
- Byte enables: an entry with i_st_byte_en==0 is accepted and drained normally; it is not filtered.
- o_ld_conflict, combinational. Asserted when i_ld_valid and either of:
  - (a) some valid entry has addr[31:2]==i_ld_addr[31:2] and (entry.byte_en & i_ld_byte_en)!=0;
  - (b) i_ld_addr>=MMIO_ADDR and count!=0.
  - There is no store-to-load forwarding. The load stalls until the matching entry drains.
  - An entry dequeuing in the current cycle still counts as a conflict.
- FSM states IDLE, DRAIN, DONE:
  - IDLE -> DRAIN on i_fence when count!=0.
  - IDLE -> DONE on i_fence when count==0.
  - DRAIN -> DONE when count==1 & dequeue, or when count==0.
  - DONE -> IDLE on the cycle after entry: o_fence_done is a single-cycle registered pulse, asserted only in DONE.
  - No enqueues are accepted in DRAIN.
  - i_fence while in DRAIN or DONE is ignored.
- Width rules:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is one bit wider so it can represent DEPTH.
- Reset mid-transfer: the in-flight head store is dropped; the memory side is reset in the same cycle.

Decomposition:
- riscv_pkg gets:
  - typedef store_buffer_entry_t {addr[31:2], data, byte_en, valid};
  - typedef from_store_buffer_t {ld_conflict, fence_done, empty}, so the hazard unit consumes a single struct;
  - localparam StoreBufferDepth.
- One sub-module, store_buffer_match: a combinational comparator array of DEPTH entries against the query, producing the per-entry match vector OR-reduced to the conflict flag.
- FIFO, FSM and pointer logic live in store_write_buffer.

Test Plan:
- Reset, then 4 stores to 0x100,0x104,0x108,0x10C with i_mem_ready=0 → o_st_ready=0 after the 4th, o_count=4. Raise i_mem_ready → addresses drain in order, one per cycle; o_empty=1 at cycle +4.
- Store 0x200 data 0xAABBCCDD byte_en 0100; load 0x202 byte_en 0100 → o_ld_conflict=1. Load 0x203 byte_en 1000 → 0. After the store drains → 0.
- count=1, MMIO load 0x4000_0000 → conflict=1 until drained. Same load with count=0 → conflict=0.
- Full buffer, simultaneous enqueue and dequeue → enqueue rejected (ready=0). At count=2, simultaneous enqueue and dequeue → count stays 2, FIFO order preserved across pointer wrap (>DEPTH stores total).
- 3 stores queued, pulse i_fence → o_st_ready=0 during drain; o_fence_done pulses exactly once, the cycle after the last acceptance. i_fence with empty buffer → pulse next cycle.
- Hold i_mem_ready=0 with o_mem_valid=1, then assert i_rst → next cycle o_mem_valid=0, o_count=0, o_st_ready=1; the held store never reaches memory.
